// File: rtl/flit_queue_pkg.sv
// Shared flit layout, timestamp width and sizing helpers for the time-gated flit queues.
package flit_queue_pkg;

    localparam int FLIT_WIDTH  = 32;
    localparam int TS_WIDTH    = 10;
    localparam int FLIT_TS_LSB = 0;
    localparam int FLIT_TS_MSB = FLIT_TS_LSB + TS_WIDTH - 1;

    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef logic [TS_WIDTH-1:0]   ts_t;

    // Queue operation for one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

    // Number of bits needed to represent value (CLogB2(15) = 4, CLogB2(1) = 1).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/ts_due_compare.sv
// Wrap-safe "timestamp has been reached" compare; shared by the time-gated queues.
module ts_due_compare #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] now,
    input  logic [WIDTH-1:0] ts,
    output logic             due
);

    localparam logic [WIDTH-1:0] HALF_RANGE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] elapsed;

    // Modular difference: anything within half the range "behind" now counts as reached.
    assign elapsed = now - ts;
    assign due     = (elapsed < HALF_RANGE);

endmodule

// File: rtl/flit_queue.sv
// Circular flit FIFO whose head is released only once its timestamp is due; one credit per pop.
module flit_queue
    import flit_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LOG_DEPTH = clogb2(DEPTH - 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [TS_WIDTH-1:0]   sim_time,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  flit_in_valid,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_out_valid,
    input  logic                  flit_ack,
    output logic                  credit_out,
    output logic                  empty,
    output logic                  full,
    output logic [LOG_DEPTH:0]    count,
    output logic                  overflow_error
);

    flit_t                mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 head_due;
    logic                 push;
    logic                 pop;
    logic                 drop;
    q_op_e                op;

    assign flit_out = mem[rd_ptr];

    ts_due_compare #(
        .WIDTH (TS_WIDTH)
    ) u_ts_due_compare (
        .now (sim_time),
        .ts  (flit_out[FLIT_TS_MSB:FLIT_TS_LSB]),
        .due (head_due)
    );

    assign empty          = (count == '0);
    assign full           = (count == (LOG_DEPTH+1)'(DEPTH));
    assign flit_out_valid = ~empty & head_due;

    // A pop frees the slot in the same cycle, so a full queue still accepts a push alongside it.
    assign pop  = enable & flit_ack & flit_out_valid;
    assign push = enable & flit_in_valid & (~full | pop);
    assign drop = enable & flit_in_valid & full & ~pop;
    assign op   = q_op_e'({push, pop});

    // NOTE: storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            credit_out     <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            credit_out <= pop;
            if (drop) begin
                overflow_error <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case (op)
                Q_PUSH:  count <= count + (LOG_DEPTH+1)'(1);
                Q_POP:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_queue.sv
// Self-checking bench for flit_queue: directed vector table, hand sequences, randomized vs. queue model.
module tb_flit_queue;
    import flit_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TS_MOD = 1 << TS_WIDTH;

    logic                   clock;
    logic                   reset;
    logic                   enable;
    ts_t                    sim_time;
    flit_t                  flit_in;
    logic                   flit_in_valid;
    flit_t                  flit_out;
    logic                   flit_out_valid;
    logic                   flit_ack;
    logic                   credit_out;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow_error;

    flit_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .sim_time       (sim_time),
        .flit_in        (flit_in),
        .flit_in_valid  (flit_in_valid),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .flit_ack       (flit_ack),
        .credit_out     (credit_out),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow_error (overflow_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: an ordered list of queued flits plus the sticky/pulse flags.
    flit_t mq[$];
    bit    m_ovf;
    bit    m_credit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input int payload, input int ts);
        return {22'(payload), 10'(ts)};
    endfunction

    function automatic bit is_due(input ts_t now, input ts_t ts);
        int d;
        d = (int'(now) - int'(ts) + TS_MOD) % TS_MOD;
        return d < TS_MOD / 2;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf    = 0;
        m_credit = 0;
    endtask

    task automatic model_step(input logic en, input logic vin, input flit_t f, input logic ack,
                              input ts_t now);
        bit head_ok;
        bit m_pop;
        bit m_push;
        head_ok = 0;
        if (mq.size() > 0) head_ok = is_due(now, mq[0][FLIT_TS_MSB:FLIT_TS_LSB]);
        m_pop  = en && ack && head_ok;
        m_push = en && vin && (mq.size() < DEPTH || m_pop);
        if (en && vin && mq.size() == DEPTH && !m_pop) m_ovf = 1;
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(f);
        m_credit = m_pop;
    endtask

    // Drive one cycle of inputs, advance the model, then sample just after the edge.
    task automatic cycle(input logic en, input logic vin, input flit_t f, input logic ack,
                         input ts_t now);
        enable        = en;
        flit_in_valid = vin;
        flit_in       = f;
        flit_ack      = ack;
        sim_time      = now;
        model_step(en, vin, f, ack, now);
        @(posedge clock);
        #1;
    endtask

    task automatic compare_model(input string tag);
        int sz;
        bit exp_valid;
        sz = mq.size();
        exp_valid = 0;
        if (sz > 0) exp_valid = is_due(sim_time, mq[0][FLIT_TS_MSB:FLIT_TS_LSB]);
        check({tag, " count"}, 32'(count), 32'(sz));
        check({tag, " empty"}, 32'(empty), 32'(sz == 0));
        check({tag, " full"}, 32'(full), 32'(sz == DEPTH));
        check({tag, " valid"}, 32'(flit_out_valid), 32'(exp_valid));
        check({tag, " credit"}, 32'(credit_out), 32'(m_credit));
        check({tag, " overflow"}, 32'(overflow_error), 32'(m_ovf));
        if (sz > 0) check({tag, " head"}, flit_out, mq[0]);
    endtask

    typedef struct {
        logic  vin;
        flit_t flit;
        logic  ack;
        ts_t   now;
        int    cnt;
        logic  valid;
        logic  credit;
        logic  ovf;
        flit_t head;
    } vec_t;

    function automatic vec_t mkv(input logic vin, input flit_t f, input logic ack, input int now,
                                 input int cnt, input logic valid, input logic credit,
                                 input logic ovf, input flit_t head);
        vec_t v;
        v.vin = vin; v.flit = f; v.ack = ack; v.now = ts_t'(now);
        v.cnt = cnt; v.valid = valid; v.credit = credit; v.ovf = ovf; v.head = head;
        return v;
    endfunction

    localparam int NV = 26;
    vec_t vecs[NV];

    initial begin
        // Ordered push/pop with immediate timestamps.
        vecs[0]  = mkv(1, mk(1, 0), 0, 0,    1, 1, 0, 0, mk(1, 0));
        vecs[1]  = mkv(1, mk(2, 0), 0, 0,    2, 1, 0, 0, mk(1, 0));
        vecs[2]  = mkv(1, mk(3, 0), 0, 0,    3, 1, 0, 0, mk(1, 0));
        vecs[3]  = mkv(0, '0,       1, 0,    2, 1, 1, 0, mk(2, 0));
        vecs[4]  = mkv(0, '0,       1, 0,    1, 1, 1, 0, mk(3, 0));
        vecs[5]  = mkv(0, '0,       1, 0,    0, 0, 1, 0, '0);
        vecs[6]  = mkv(0, '0,       0, 0,    0, 0, 0, 0, '0);
        // Future timestamp gates the head; ack while not valid is ignored.
        vecs[7]  = mkv(1, mk(4, 5), 0, 4,    1, 0, 0, 0, mk(4, 5));
        vecs[8]  = mkv(0, '0,       1, 4,    1, 0, 0, 0, mk(4, 5));
        vecs[9]  = mkv(0, '0,       0, 5,    1, 1, 0, 0, mk(4, 5));
        vecs[10] = mkv(0, '0,       1, 5,    0, 0, 1, 0, '0);
        // Timestamp wrap-around.
        vecs[11] = mkv(1, mk(5, 1020), 0, 2,    1, 1, 0, 0, mk(5, 1020));
        vecs[12] = mkv(0, '0,          1, 2,    0, 0, 1, 0, '0);
        vecs[13] = mkv(1, mk(6, 2),    0, 1020, 1, 0, 0, 0, mk(6, 2));
        vecs[14] = mkv(0, '0,          1, 1020, 1, 0, 0, 0, mk(6, 2));
        vecs[15] = mkv(0, '0,          1, 2,    0, 0, 1, 0, '0);
        // Fill, overflow drop, push+pop on full, drain in order.
        vecs[16] = mkv(1, mk(7, 0),  0, 0,  1, 1, 0, 0, mk(7, 0));
        vecs[17] = mkv(1, mk(8, 0),  0, 0,  2, 1, 0, 0, mk(7, 0));
        vecs[18] = mkv(1, mk(9, 0),  0, 0,  3, 1, 0, 0, mk(7, 0));
        vecs[19] = mkv(1, mk(10, 0), 0, 0,  4, 1, 0, 0, mk(7, 0));
        vecs[20] = mkv(1, mk(11, 0), 0, 0,  4, 1, 0, 1, mk(7, 0));
        vecs[21] = mkv(1, mk(12, 0), 1, 0,  4, 1, 1, 1, mk(8, 0));
        vecs[22] = mkv(0, '0,        1, 0,  3, 1, 1, 1, mk(9, 0));
        vecs[23] = mkv(0, '0,        1, 0,  2, 1, 1, 1, mk(10, 0));
        vecs[24] = mkv(0, '0,        1, 0,  1, 1, 1, 1, mk(12, 0));
        vecs[25] = mkv(0, '0,        1, 0,  0, 0, 1, 1, '0);

        reset         = 1'b0;
        enable        = 1'b0;
        sim_time      = '0;
        flit_in       = '0;
        flit_in_valid = 1'b0;
        flit_ack      = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset valid", 32'(flit_out_valid), 32'd0);
        check("reset credit", 32'(credit_out), 32'd0);
        check("reset overflow", 32'(overflow_error), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cycle(1'b1, vecs[i].vin, vecs[i].flit, vecs[i].ack, vecs[i].now);
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].cnt == DEPTH));
            check($sformatf("vec%0d valid", i), 32'(flit_out_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d credit", i), 32'(credit_out), 32'(vecs[i].credit));
            check($sformatf("vec%0d overflow", i), 32'(overflow_error), 32'(vecs[i].ovf));
            if (vecs[i].cnt > 0) check($sformatf("vec%0d head", i), flit_out, vecs[i].head);
        end

        // Global enable low freezes the queue even with push and ack requested.
        cycle(1'b1, 1'b1, mk(21, 0), 1'b0, '0);
        cycle(1'b1, 1'b1, mk(22, 0), 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        compare_model("pre-hold");
        repeat (2) begin
            cycle(1'b0, 1'b1, mk(23, 0), 1'b1, '0);
            compare_model("hold");
            check("hold count", 32'(count), 32'd2);
            check("hold credit", 32'(credit_out), 32'd0);
            check("hold head", flit_out, mk(21, 0));
        end
        cycle(1'b1, 1'b1, mk(24, 0), 1'b0, '0);
        cycle(1'b1, 1'b1, mk(25, 0), 1'b1, '0);
        compare_model("pre-reset");
        check("pre-reset count", 32'(count), 32'd3);
        check("pre-reset credit", 32'(credit_out), 32'd1);

        // Asynchronous reset mid-operation, away from any clock edge.
        #2 reset = 1'b0;
        #1;
        model_clear();
        check("async count", 32'(count), 32'd0);
        check("async empty", 32'(empty), 32'd1);
        check("async credit", 32'(credit_out), 32'd0);
        check("async overflow", 32'(overflow_error), 32'd0);
        check("async valid", 32'(flit_out_valid), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, '0);
        model_clear();
        compare_model("in-reset");
        reset = 1'b1;
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        compare_model("post-reset");

        // Randomized traffic against the model with a wandering time base.
        begin
            int now;
            now = 0;
            for (int c = 0; c < 600; c++) begin
                logic en;
                logic vin;
                logic ack;
                int   ts;
                en  = ($urandom_range(0, 9) != 0);
                vin = ($urandom_range(0, 9) < 6);
                ack = ($urandom_range(0, 9) < 6);
                now = (now + int'($urandom_range(0, 2))) % TS_MOD;
                ts  = (now + int'($urandom_range(0, 10)) - 4 + TS_MOD) % TS_MOD;
                cycle(en, vin, {22'($urandom), 10'(ts)}, ack, ts_t'(now));
                compare_model($sformatf("rnd%0d", c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_queue.md
FLIT_QUEUE -- requirements
Module: flit_queue

Interface
REQ-001 Parameter DEPTH, default 16, means the flit storage entries; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter LOG_DEPTH, default CLogB2(DEPTH-1), means the pointer width.
REQ-003 Port clock, input, 1 bit, is the single clock; all state SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, is the asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit, is the global step enable; when low, all state SHALL hold.
REQ-006 Port sim_time, input, `TS_WIDTH bits, is the current simulation time.
REQ-007 Port flit_in, input, `FLIT_WIDTH bits, is the incoming link flit.
REQ-008 Port flit_in_valid, input, 1 bit, is the push request.
REQ-009 Port flit_out, output, `FLIT_WIDTH bits, is the head flit presented to the router input stage.
REQ-010 Port flit_out_valid, output, 1 bit, means the head exists and is due.
REQ-011 Port flit_ack, input, 1 bit, is the pop request from the router input stage.
REQ-012 Port credit_out, output, 1 bit, is a one-cycle pulse per popped flit, returned upstream.
REQ-013 Port empty, output, 1 bit, is the empty flag.
REQ-014 Port full, output, 1 bit, is the full flag.
REQ-015 Port count, output, LOG_DEPTH+1 bits, is the occupancy.
REQ-016 Port overflow_error, output, 1 bit, is a sticky flag for a dropped push.

Function
REQ-017 Storage SHALL be a circular register array with wr_ptr and rd_ptr of LOG_DEPTH bits that wrap DEPTH-1 -> 0, plus a LOG_DEPTH+1-bit count.
REQ-018 flit_out SHALL be a combinational read of entry rd_ptr; it is don't-care when empty.
REQ-019 Head timestamp SHALL be flit_out[`FLIT_TS_MSB:`FLIT_TS_LSB].
REQ-020 The head is due when (sim_time - head_ts) mod 2^TS_WIDTH < 2^(TS_WIDTH-1); this is a wrap-safe compare.
REQ-021 flit_out_valid SHALL equal ~empty & due.
REQ-022 A push SHALL occur when enable & flit_in_valid & (~full | pop).
REQ-023 A pop SHALL occur when enable & flit_ack & flit_out_valid.
REQ-024 A flit_ack while flit_out_valid is low SHALL be ignored, with no state change.
REQ-025 A push writes flit_in to wr_ptr; the flit SHALL be visible at the head no earlier than the next cycle (no write-to-read bypass).
REQ-026 Push and pop in the same cycle SHALL both take effect, leaving count unchanged; this includes the full case.
REQ-027 Push-only SHALL do count+1, pop-only count-1, and neither SHALL hold.
REQ-028 empty SHALL be (count==0) and full SHALL be (count==DEPTH), both derived from registered count.
REQ-029 enable & flit_in_valid & full & ~pop SHALL drop the flit, leave pointers and count unchanged, and set overflow_error; overflow_error clears only on reset.
REQ-030 credit_out SHALL be registered: it is high for exactly the one cycle after each pop, and low otherwise.
REQ-031 A head that is not due SHALL block the entries behind it (strict FIFO order, no reordering).

Reset
REQ-032 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, credit_out and overflow_error.
REQ-033 Out of reset, outputs SHALL be empty=1, full=0, count=0, flit_out_valid=0, credit_out=0 and overflow_error=0; array contents are not reset.
REQ-034 Reset mid-operation SHALL discard all queued flits and SHALL produce no credit pulse for them.

Structure
REQ-035 `FLIT_WIDTH, `TS_WIDTH, `FLIT_TS_MSB and `FLIT_TS_LSB SHALL live in the shared constants header alongside existing flit field definitions; CLogB2 SHALL come from the shared math header.
REQ-036 The block is one module; the wrap-safe due comparator SHALL be a sub-module named ts_due_compare (inputs now and ts, output due), reused by other time-gated queues.

Verification
REQ-037 Scenario: reset low then high, push 3 flits with ts=0 and sim_time=0 -> flit_out_valid=1 from the cycle after the first push, count=3, and flits pop in order with one credit_out pulse each.
REQ-038 Scenario: push a flit with ts=5 and sim_time=4 -> flit_out_valid=0 and flit_ack is ignored; with sim_time=5 -> flit_out_valid=1.
REQ-039 Scenario: wrap check with TS_WIDTH=10, ts=1020 and sim_time=2 -> due; ts=2 and sim_time=1020 -> not due.
REQ-040 Scenario: DEPTH=4, fill to full=1, then push with no ack -> overflow_error=1 and count=4; then push plus ack in the same cycle -> count stays 4 with the new flit at the tail.
REQ-041 Scenario: push a fifth flit on full -> overflow_error=1, and the popped order is unaffected.
REQ-042 Scenario: enable=0 with push and ack asserted -> no change to count, pointers or credit_out.
REQ-043 Scenario: reset asserted with count=3 -> count=0 and empty=1 asynchronously, with no credit_out pulse.
